// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO buffering bytes ahead of the serialiser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = UART_DATA_BITS
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_count_next;

  // A write while full is refused even if a pop happens on the same edge.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: rtl/uart_byte_tx.sv
// Buffers a byte stream and serialises it as back-to-back 8N1 frames with optional parity.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       enable,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned     CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned     CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned     FCW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT     = 3'(UART_DATA_BITS - 1);

  tx_state_t        r_state;
  tx_state_t        w_state_next;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_parity;
  logic             w_parity_next;
  logic             r_tx;
  logic             w_tx_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_overflow;
  logic             w_bit_end;
  logic             w_pop;
  logic             w_wr_acc;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_fifo_data;
  logic [FCW-1:0]   w_fifo_count;
  logic [FCW-1:0]   w_count_next;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (enable),
    .wr_data (din),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .count   (w_fifo_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_bit_end = (r_baud_cnt == LAST_CNT);
  assign w_wr_acc  = enable & ~w_fifo_full;
  // Popping at the end of STOP lets the next start bit follow with no idle gap.
  assign w_pop     = ~w_fifo_empty &
                     ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (!w_fifo_empty) w_state_next = START;
      START:  if (w_bit_end) w_state_next = DATA;
      DATA:   if (w_bit_end && (r_bit_idx == LAST_BIT))
                w_state_next = PARITY_EN ? PARITY : STOP;
      PARITY: if (w_bit_end) w_state_next = STOP;
      STOP:   if (w_bit_end) w_state_next = w_fifo_empty ? IDLE : START;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so tx/busy can be registered.
  always_comb begin
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    if (w_pop) begin
      w_shift_next  = w_fifo_data;
      w_parity_next = (^w_fifo_data) ^ PARITY_ODD;
    end else if ((r_state == DATA) && w_bit_end) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end

    case ({w_wr_acc, w_pop})
      2'b10:   w_count_next = w_fifo_count + FCW'(1);
      2'b01:   w_count_next = w_fifo_count - FCW'(1);
      default: w_count_next = w_fifo_count;
    endcase
    w_busy_next = (w_state_next != IDLE) | (w_count_next != '0);

    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_parity_next;
      default: w_tx_next = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= UART_IDLE_LVL;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if ((r_state == IDLE) || w_bit_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
      end
      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_overflow <= enable & w_fifo_full;
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign full     = w_fifo_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed and randomized checks of uart_byte_tx against a frame-level line model.
module tb_uart_byte_tx;

  localparam int unsigned CPB = 400 / 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       enable  = 1'b0;
  logic [7:0] din     = 8'h00;

  logic tx0, busy0, full0, ovf0;
  logic tx1, busy1, full1, ovf1;
  logic tx2, busy2, full2, ovf2;

  int n_assert = 0;
  int n_fail   = 0;

  logic       exp_q0[$];
  logic       exp_q1[$];
  logic       exp_q2[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  bit         rx_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_byte_tx #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(4),
                 .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .din(din),
    .tx(tx0), .busy(busy0), .full(full0), .overflow(ovf0));

  uart_byte_tx #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(4),
                 .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .din(din),
    .tx(tx1), .busy(busy1), .full(full1), .overflow(ovf1));

  uart_byte_tx #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(4),
                 .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .din(din),
    .tx(tx2), .busy(busy2), .full(full2), .overflow(ovf2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      1:       return tx1;
      2:       return tx2;
      default: return tx0;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return busy1;
      2:       return busy2;
      default: return busy0;
    endcase
  endfunction

  // Line model: start 0, data LSB first, optional parity, stop 1; each bit CPB cycles.
  task automatic add_frame(input int sel, input logic [7:0] b,
                           input bit par_en, input bit par_odd);
    logic bits[$];
    int   ones;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    ones = $countones(b);
    if (par_en) bits.push_back(par_odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < int'(CPB); c++) begin
        case (sel)
          1:       exp_q1.push_back(bits[i]);
          2:       exp_q2.push_back(bits[i]);
          default: exp_q0.push_back(bits[i]);
        endcase
      end
    end
  endtask

  task automatic compare_wave(input string tag, input int sel);
    int   n;
    logic e;
    case (sel)
      1:       n = exp_q1.size();
      2:       n = exp_q2.size();
      default: n = exp_q0.size();
    endcase
    for (int k = 0; k < n; k++) begin
      case (sel)
        1:       e = exp_q1[k];
        2:       e = exp_q2[k];
        default: e = exp_q0[k];
      endcase
      check($sformatf("%s tx[%0d]", tag, k), get_tx(sel), e);
      check($sformatf("%s busy[%0d]", tag, k), get_busy(sel), 1'b1);
      @(negedge sys_clk);
    end
    case (sel)
      1:       exp_q1.delete();
      2:       exp_q2.delete();
      default: exp_q0.delete();
    endcase
  endtask

  // Mid-bit sampling receiver on dut0, used for the randomized traffic.
  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      @(negedge sys_clk);
      if (rx_en && (tx0 == 1'b0)) begin
        repeat (CPB / 2) @(negedge sys_clk);
        check("rx start", tx0, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sys_clk);
          b[i] = tx0;
        end
        repeat (CPB) @(negedge sys_clk);
        check("rx stop", tx0, 1'b1);
        repeat (CPB / 2 - 1) @(negedge sys_clk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         t;
    int         nb;
    logic [7:0] b;

    // Reset
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset tx", tx0, 1'b1);
    check("reset busy", busy0, 1'b0);
    check("reset full", full0, 1'b0);
    check("reset overflow", ovf0, 1'b0);
    sys_rst = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      check("idle tx", tx0, 1'b1);
      check("idle busy", busy0, 1'b0);
    end

    // Single byte
    enable = 1'b1; din = 8'hA5;
    @(negedge sys_clk);
    enable = 1'b0;
    check("single busy after write", busy0, 1'b1);
    check("single tx before pop", tx0, 1'b1);
    add_frame(0, 8'hA5, 1'b0, 1'b0);
    @(negedge sys_clk);
    compare_wave("single", 0);
    check("single busy drop", busy0, 1'b0);
    check("single tx idle", tx0, 1'b1);

    // Back-to-back
    enable = 1'b1; din = 8'h55;
    @(negedge sys_clk);
    din = 8'h0F;
    check("b2b tx before pop", tx0, 1'b1);
    @(negedge sys_clk);
    enable = 1'b0;
    add_frame(0, 8'h55, 1'b0, 1'b0);
    add_frame(0, 8'h0F, 1'b0, 1'b0);
    compare_wave("b2b", 0);
    check("b2b busy drop", busy0, 1'b0);

    // Overflow
    enable = 1'b1; din = 8'h01;
    @(negedge sys_clk);
    din = 8'h02;
    @(negedge sys_clk);
    for (int i = 1; i <= 5; i++) add_frame(0, 8'(i), 1'b0, 1'b0);
    fork
      compare_wave("ovf", 0);
      begin
        din = 8'h03;
        @(negedge sys_clk);
        din = 8'h04;
        @(negedge sys_clk);
        check("ovf full before", full0, 1'b0);
        din = 8'h05;
        @(negedge sys_clk);
        check("ovf full", full0, 1'b1);
        check("ovf no pulse yet", ovf0, 1'b0);
        din = 8'h06;
        @(negedge sys_clk);
        enable = 1'b0;
        check("ovf pulse", ovf0, 1'b1);
        check("ovf still full", full0, 1'b1);
        @(negedge sys_clk);
        check("ovf pulse ends", ovf0, 1'b0);
      end
    join
    check("ovf busy drop", busy0, 1'b0);
    check("ovf full clear", full0, 1'b0);

    // Parity (dut1 even, dut2 odd)
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    enable = 1'b1; din = 8'h07;
    @(negedge sys_clk);
    enable = 1'b0;
    add_frame(1, 8'h07, 1'b1, 1'b0);
    add_frame(2, 8'h07, 1'b1, 1'b1);
    @(negedge sys_clk);
    fork
      compare_wave("par_even", 1);
      compare_wave("par_odd", 2);
    join
    check("par_even busy drop", busy1, 1'b0);
    check("par_odd busy drop", busy2, 1'b0);
    check("par_even full", full1, 1'b0);
    check("par_odd overflow", ovf2, 1'b0);
    check("par_even overflow", ovf1, 1'b0);
    check("par_odd full", full2, 1'b0);
    repeat (4) @(negedge sys_clk);
    check("par dut0 idle", busy0, 1'b0);

    // Reset mid-frame, with a queued byte that must be discarded
    enable = 1'b1; din = 8'hFF;
    @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    enable = 1'b1; din = 8'hAA;
    @(negedge sys_clk);
    enable = 1'b0;
    repeat (15) @(negedge sys_clk);
    check("midrst busy before", busy0, 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst tx", tx0, 1'b1);
    check("midrst busy", busy0, 1'b0);
    check("midrst full", full0, 1'b0);
    sys_rst = 1'b0;
    repeat (8) begin
      @(negedge sys_clk);
      check("midrst fifo discarded tx", tx0, 1'b1);
      check("midrst fifo discarded busy", busy0, 1'b0);
    end
    enable = 1'b1; din = 8'h3C;
    @(negedge sys_clk);
    enable = 1'b0;
    add_frame(0, 8'h3C, 1'b0, 1'b0);
    @(negedge sys_clk);
    compare_wave("after_rst", 0);
    check("after_rst busy drop", busy0, 1'b0);

    // Randomized bursts decoded by the receiver
    rx_q.delete();
    sent_q.delete();
    rx_en = 1'b1;
    for (int burst = 0; burst < 6; burst++) begin
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        enable = 1'b1; din = b;
        sent_q.push_back(b);
        @(negedge sys_clk);
        enable = 1'b0;
        repeat ($urandom_range(0, 30)) begin
          @(negedge sys_clk);
          check("rnd no overflow", ovf0, 1'b0);
        end
      end
      t = 0;
      while (busy0 && (t < 500)) begin
        @(negedge sys_clk);
        t++;
      end
      check($sformatf("rnd burst %0d drained", burst), (t < 500), 1'b1);
    end
    repeat (4) @(negedge sys_clk);
    rx_en = 1'b0;
    check("rnd byte count", rx_q.size(), sent_q.size());
    foreach (sent_q[i]) begin
      if (i < rx_q.size()) check($sformatf("rnd byte %0d", i), rx_q[i], sent_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Downstream consumer of uart_send_source.
- Accepts the byte stream that block produces: an `enable` strobe plus `dout[7:0]`, connected here as `din`.
- Buffers the bytes in a small FIFO and serialises them onto the Bluetooth module's UART RX pin as 8N1 frames, with optional parity.
- Back-to-back bytes are sent with no idle gap. Overflow is flagged, never silently corrupted.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- BAUD, 9600: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, must be ≥ 2.
- FIFO_DEPTH, 4: byte buffer depth, power of two, ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit between D7 and the stop bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- sys_clk, input, 1: system clock, rising edge.
- sys_rst, input, 1: synchronous reset, active-high.
- enable, input, 1: one-cycle write strobe for din.
- din, input, 8: byte to transmit, sampled when enable = 1.
- tx, output, 1: UART serial output, idles high.
- busy, output, 1: high while a frame is in progress or the FIFO is non-empty.
- full, output, 1: FIFO count == FIFO_DEPTH.
- overflow, output, 1: one-cycle pulse when a write is dropped.

Behaviour:
- Only one clock and one reset exist. Reset is synchronous and active-high: sys_rst is sampled on the sys_clk rising edge.
- Reset values:
  - tx = 1, busy = 0, full = 0, overflow = 0.
  - FIFO pointers and count = 0; baud counter = 0; bit index = 0; state = IDLE.
- Reset mid-frame aborts the frame, discards FIFO contents, and forces tx high on the same edge.
- FIFO write rule:
  - A write is accepted iff enable = 1 and count < FIFO_DEPTH before the edge.
  - enable = 1 with full = 1 drops the byte and pulses overflow for exactly one cycle, on the next cycle.
  - A pop on the same edge does not rescue a write attempted while full (full is evaluated pre-edge).
  - A simultaneous accepted write and pop leaves count unchanged.
- State machine:
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit holds for CLKS_PER_BIT cycles. After bit index 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = ^byte XOR PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle bit); else go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Its wrap marks the bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
- Latency:
  - With the block idle and the FIFO empty, a write on edge N makes the FIFO non-empty after N.
  - The pop and IDLE→START happen on edge N+1, so tx falls after edge N+1.
- Frame length:
  - (10 + PARITY_EN) × CLKS_PER_BIT cycles.
  - Consecutive frames abut exactly.
- busy = (state != IDLE) | (count != 0).
- tx, busy and full are registered outputs; tx has no combinational path from inputs.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam function for CLKS_PER_BIT;
  - constants UART_IDLE_LVL = 1'b1 and UART_DATA_BITS = 8.
- One natural sub-module: uart_tx_fifo, a synchronous FIFO.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Parameterised by depth; same sys_clk and sys_rst.
- The FSM and baud counter live in uart_byte_tx.

Test Plan (CLK_FREQ = 400, BAUD = 100 → CLKS_PER_BIT = 4, FIFO_DEPTH = 4, PARITY_EN = 0 unless stated):
- Reset check: assert sys_rst for 3 cycles → tx = 1, busy = 0, full = 0, overflow = 0. Deasserting reset with no enable leaves tx = 1 indefinitely.
- Single byte: enable with din = 0xA5 on edge N.
  - tx low for 4 cycles starting after edge N+1.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  - busy drops after edge N+41.
- Back-to-back: enable 0x55 and 0x0F on consecutive cycles → two 40-cycle frames with no high gap between the first stop bit and the second start bit.
- Overflow: 6 consecutive enables, bytes 0x01..0x06, while idle.
  - 0x01 pops at once and 0x02..0x05 fill the FIFO, so full rises.
  - The 6th write (0x06) is dropped and overflow pulses one cycle.
  - The line carries exactly 0x01..0x05 in order.
- Parity (PARITY_EN = 1): 0x07 with PARITY_ODD = 0 gives parity bit 1; with PARITY_ODD = 1 gives parity bit 0. Frame length is 44 cycles.
- Reset mid-frame: send 0xFF, assert sys_rst during DATA bit 3 → tx = 1 on the next edge, busy = 0, FIFO empty. A subsequent 0x3C transmits correctly.
